// File: rtl/single_argmax.sv
// Sequential argmax over a captured vector of IEEE-754 single-precision values.
// The comparison uses an integer ordering key, so no floating-point unit is needed.
module single_argmax #(
    parameter int HEIGHT  = 10,
    parameter int INDEX_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic [31:0]        vector_in [HEIGHT],
    output logic               busy,
    output logic               done,
    output logic [INDEX_W-1:0] max_index,
    output logic [31:0]        max_value,
    output logic               all_nan
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t             state;
    logic [31:0]        vec_q [HEIGHT];
    logic [INDEX_W-1:0] counter;
    logic [31:0]        best_key;
    logic               best_valid;

    logic [31:0]        cur_elem;
    logic [31:0]        cur_key;
    logic               cur_nan;
    logic               take;
    logic               last;

    // -0 folds onto +0 so the two tie and the lower index wins.
    function automatic logic [31:0] order_key(input logic [31:0] bits);
        logic [31:0] b;
        b = (bits == 32'h8000_0000) ? 32'h0000_0000 : bits;
        return b[31] ? ~b : {1'b1, b[30:0]};
    endfunction

    always_comb begin
        cur_elem = vec_q[0];
        for (int i = 1; i < HEIGHT; i++) begin
            if (counter == INDEX_W'(i)) cur_elem = vec_q[i];
        end
    end

    assign cur_nan = (cur_elem[30:23] == 8'hFF) && (cur_elem[22:0] != 23'd0);
    assign cur_key = order_key(cur_elem);
    assign take    = !cur_nan && (!best_valid || (cur_key > best_key));
    assign last    = (counter == INDEX_W'(HEIGHT - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            max_index  <= '0;
            max_value  <= '0;
            all_nan    <= 1'b0;
            counter    <= '0;
            best_key   <= '0;
            best_valid <= 1'b0;
            for (int i = 0; i < HEIGHT; i++) vec_q[i] <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        for (int i = 0; i < HEIGHT; i++) vec_q[i] <= vector_in[i];
                        counter    <= '0;
                        best_valid <= 1'b0;
                        state      <= SCAN;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        all_nan    <= 1'b0;
                    end
                end
                SCAN: begin
                    if (take) begin
                        best_key   <= cur_key;
                        best_valid <= 1'b1;
                        max_index  <= counter;
                        max_value  <= cur_elem;
                    end
                    counter <= counter + 1'b1;
                    if (last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        // Nothing usable was seen: report element 0 and flag it.
                        if (!best_valid && !take) begin
                            max_index <= '0;
                            max_value <= vec_q[0];
                            all_nan   <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_single_argmax.sv
// Scoreboard bench for single_argmax: a HEIGHT=4 and a HEIGHT=1 instance share clock and reset.
module tb_single_argmax;

    typedef struct {
        logic [1:0]  idx;
        logic [31:0] val;
        logic        nan;
    } exp4_t;

    typedef struct {
        logic        idx;
        logic [31:0] val;
        logic        nan;
    } exp1_t;

    typedef struct {
        logic [31:0] v0, v1, v2, v3;
        logic [1:0]  idx;
        logic [31:0] val;
        logic        nan;
    } case_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start4, start1;
    logic [31:0] vec4 [4];
    logic [31:0] vec1 [1];
    logic        busy4, done4, nan4;
    logic [1:0]  idx4;
    logic [31:0] val4;
    logic        busy1, done1, nan1;
    logic        idx1;
    logic [31:0] val1;

    exp4_t sb4[$];
    exp1_t sb1[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    single_argmax #(.HEIGHT(4)) dut4 (
        .clk(clk), .rstn(rstn), .start(start4), .vector_in(vec4),
        .busy(busy4), .done(done4), .max_index(idx4), .max_value(val4), .all_nan(nan4)
    );

    single_argmax #(.HEIGHT(1)) dut1 (
        .clk(clk), .rstn(rstn), .start(start1), .vector_in(vec1),
        .busy(busy1), .done(done1), .max_index(idx1), .max_value(val1), .all_nan(nan1)
    );

    task automatic drive4(input logic [31:0] v0, v1, v2, v3);
        @(negedge clk);
        vec4[0] = v0; vec4[1] = v1; vec4[2] = v2; vec4[3] = v3;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
    endtask

    task automatic wait4(output int cycles);
        cycles = 0;
        while (done4 !== 1'b1 && cycles < 64) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic wait1(output int cycles);
        cycles = 0;
        while (done1 !== 1'b1 && cycles < 64) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        start4 = 1'b0;
        start1 = 1'b0;
        for (int i = 0; i < 4; i++) vec4[i] = '0;
        vec1[0] = '0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({busy4, done4, idx4, val4, nan4} !== 36'd0) begin
            errors++;
            $display("[TB] FAIL reset4: got busy=%b done=%b idx=%0d val=%h nan=%b, want all zero",
                     busy4, done4, idx4, val4, nan4);
        end
        checks++;
        if ({busy1, done1, idx1, val1, nan1} !== 35'd0) begin
            errors++;
            $display("[TB] FAIL reset1: got busy=%b done=%b idx=%0d val=%h nan=%b, want all zero",
                     busy1, done1, idx1, val1, nan1);
        end
        rstn = 1'b1;
    endtask

    task automatic test_ordering;
        case_t cases[7];
        exp4_t e;
        int    c;
        cases = '{
            '{32'h3F800000, 32'h40000000, 32'hBF800000, 32'h3F800000, 2'd1, 32'h40000000, 1'b0},
            '{32'hBF800000, 32'hC0400000, 32'hBF800000, 32'hC0400000, 2'd0, 32'hBF800000, 1'b0},
            '{32'h7FC00000, 32'h80000000, 32'h00000000, 32'hFF800000, 2'd1, 32'h80000000, 1'b0},
            '{32'h7FC00000, 32'h80000000, 32'h00000000, 32'h7F800000, 2'd3, 32'h7F800000, 1'b0},
            '{32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 2'd0, 32'h7FC00000, 1'b1},
            '{32'hFF800000, 32'h7F800001, 32'hC1200000, 32'hBF000000, 2'd3, 32'hBF000000, 1'b0},
            '{32'h7F7FFFFF, 32'hFF800000, 32'h7FFFFFFF, 32'h00000001, 2'd0, 32'h7F7FFFFF, 1'b0}
        };
        foreach (cases[k]) begin
            sb4.push_back('{cases[k].idx, cases[k].val, cases[k].nan});
            drive4(cases[k].v0, cases[k].v1, cases[k].v2, cases[k].v3);
            checks++;
            if ({busy4, done4} !== 2'b10) begin
                errors++;
                $display("[TB] FAIL ordering_accept[%0d]: got busy=%b done=%b, want busy=1 done=0",
                         k, busy4, done4);
            end
            wait4(c);
            checks++;
            if (c != 4) begin
                errors++;
                $display("[TB] FAIL ordering_latency[%0d]: got %0d cycles, want 4", k, c);
            end
            e = sb4.pop_front();
            checks++;
            if ({done4, busy4, idx4, val4, nan4} !== {1'b1, 1'b0, e.idx, e.val, e.nan}) begin
                errors++;
                $display("[TB] FAIL ordering_result[%0d]: got done=%b busy=%b idx=%0d val=%h nan=%b, want done=1 busy=0 idx=%0d val=%h nan=%b",
                         k, done4, busy4, idx4, val4, nan4, e.idx, e.val, e.nan);
            end
        end
    endtask

    task automatic test_ignore_midscan;
        exp4_t e;
        int    c;
        sb4.push_back('{2'd1, 32'h40000000, 1'b0});
        drive4(32'h3F800000, 32'h40000000, 32'hBF800000, 32'h3F800000);
        @(negedge clk);
        vec4[0] = 32'h7F800000; vec4[1] = 32'h0; vec4[2] = 32'h0; vec4[3] = 32'h0;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        wait4(c);
        checks++;
        if (c != 2) begin
            errors++;
            $display("[TB] FAIL midscan_latency: got %0d remaining cycles, want 2", c);
        end
        e = sb4.pop_front();
        checks++;
        if ({done4, busy4, idx4, val4, nan4} !== {1'b1, 1'b0, e.idx, e.val, e.nan}) begin
            errors++;
            $display("[TB] FAIL midscan_result: got done=%b busy=%b idx=%0d val=%h nan=%b, want done=1 busy=0 idx=%0d val=%h nan=%b",
                     done4, busy4, idx4, val4, nan4, e.idx, e.val, e.nan);
        end
    endtask

    task automatic test_back_to_back;
        exp4_t e;
        int    c;
        // Restart straight out of DONE with the vector changed earlier.
        sb4.push_back('{2'd0, 32'h7F800000, 1'b0});
        drive4(32'h7F800000, 32'h0, 32'h0, 32'h0);
        checks++;
        if ({busy4, done4} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL restart_accept: got busy=%b done=%b, want busy=1 done=0", busy4, done4);
        end
        wait4(c);
        e = sb4.pop_front();
        checks++;
        if (c != 4 || {done4, idx4, val4, nan4} !== {1'b1, e.idx, e.val, e.nan}) begin
            errors++;
            $display("[TB] FAIL restart_result: got cycles=%0d done=%b idx=%0d val=%h nan=%b, want cycles=4 done=1 idx=%0d val=%h nan=%b",
                     c, done4, idx4, val4, nan4, e.idx, e.val, e.nan);
        end
        // start held high: every DONE entry immediately re-accepts.
        vec4[0] = 32'hC0400000; vec4[1] = 32'hBF800000; vec4[2] = 32'h7FC00000; vec4[3] = 32'hBF800000;
        sb4.push_back('{2'd1, 32'hBF800000, 1'b0});
        sb4.push_back('{2'd1, 32'hBF800000, 1'b0});
        start4 = 1'b1;
        @(negedge clk);
        wait4(c);
        e = sb4.pop_front();
        checks++;
        if (c != 4 || {done4, idx4, val4, nan4} !== {1'b1, e.idx, e.val, e.nan}) begin
            errors++;
            $display("[TB] FAIL held_first: got cycles=%0d done=%b idx=%0d val=%h nan=%b, want cycles=4 done=1 idx=%0d val=%h nan=%b",
                     c, done4, idx4, val4, nan4, e.idx, e.val, e.nan);
        end
        @(negedge clk);
        checks++;
        if ({busy4, done4} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL held_one_cycle: got busy=%b done=%b, want busy=1 done=0", busy4, done4);
        end
        wait4(c);
        e = sb4.pop_front();
        start4 = 1'b0;
        checks++;
        if (c != 4 || {done4, idx4, val4, nan4} !== {1'b1, e.idx, e.val, e.nan}) begin
            errors++;
            $display("[TB] FAIL held_second: got cycles=%0d done=%b idx=%0d val=%h nan=%b, want cycles=4 done=1 idx=%0d val=%h nan=%b",
                     c, done4, idx4, val4, nan4, e.idx, e.val, e.nan);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({busy4, done4, idx4, val4} !== {1'b0, 1'b1, 2'd1, 32'hBF800000}) begin
            errors++;
            $display("[TB] FAIL done_hold: got busy=%b done=%b idx=%0d val=%h, want busy=0 done=1 idx=1 val=bf800000",
                     busy4, done4, idx4, val4);
        end
    endtask

    task automatic test_reset_midscan;
        exp4_t e;
        int    c;
        drive4(32'h3F800000, 32'h40000000, 32'hBF800000, 32'h3F800000);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        checks++;
        if ({busy4, done4, idx4, val4, nan4} !== 36'd0) begin
            errors++;
            $display("[TB] FAIL reset_midscan: got busy=%b done=%b idx=%0d val=%h nan=%b, want all zero",
                     busy4, done4, idx4, val4, nan4);
        end
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({busy4, done4} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_no_done: got busy=%b done=%b, want 0 0", busy4, done4);
        end
        rstn = 1'b1;
        sb4.push_back('{2'd0, 32'hBF800000, 1'b0});
        drive4(32'hBF800000, 32'hC0400000, 32'hBF800000, 32'hC0400000);
        wait4(c);
        e = sb4.pop_front();
        checks++;
        if (c != 4 || {done4, busy4, idx4, val4, nan4} !== {1'b1, 1'b0, e.idx, e.val, e.nan}) begin
            errors++;
            $display("[TB] FAIL post_reset_result: got cycles=%0d done=%b busy=%b idx=%0d val=%h nan=%b, want cycles=4 done=1 busy=0 idx=%0d val=%h nan=%b",
                     c, done4, busy4, idx4, val4, nan4, e.idx, e.val, e.nan);
        end
    endtask

    task automatic test_single_element;
        logic [31:0] vals[2];
        exp1_t       e;
        int          c;
        vals = '{32'hC0400000, 32'h7FC00000};
        sb1.push_back('{1'b0, 32'hC0400000, 1'b0});
        sb1.push_back('{1'b0, 32'h7FC00000, 1'b1});
        foreach (vals[k]) begin
            @(negedge clk);
            vec1[0] = vals[k];
            start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
            wait1(c);
            e = sb1.pop_front();
            checks++;
            if (c != 1 || {done1, busy1, idx1, val1, nan1} !== {1'b1, 1'b0, e.idx, e.val, e.nan}) begin
                errors++;
                $display("[TB] FAIL single[%0d]: got cycles=%0d done=%b busy=%b idx=%0d val=%h nan=%b, want cycles=1 done=1 busy=0 idx=%0d val=%h nan=%b",
                         k, c, done1, busy1, idx1, val1, nan1, e.idx, e.val, e.nan);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ordering();
        test_ignore_midscan();
        test_back_to_back();
        test_reset_midscan();
        test_single_element();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
